// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC field-arithmetic datapath.
package ecc_pkg;

  // Default field width (operands and modulus), in bits.
  localparam int ECC_LEN = 256;

  // Sequencer states of the bit-serial modular multiplier.
  typedef enum logic [1:0] {
    MM_IDLE = 2'd0,
    MM_RUN  = 2'd1,
    MM_DONE = 2'd2
  } mm_state_t;

endpackage

// File: rtl/mod_add.sv
// Combinational modular adder: s = (x + y) mod p, valid for x, y < p.
// One conditional subtract is enough because x + y < 2p under that precondition.
module mod_add
  import ecc_pkg::*;
#(
  parameter int LEN = ECC_LEN
) (
  input  logic [LEN-1:0] x,
  input  logic [LEN-1:0] y,
  input  logic [LEN-1:0] p,
  output logic [LEN-1:0] s
);

  // The sum needs one extra bit: x + y can reach 2p - 2, which may not fit in LEN bits.
  logic [LEN:0] sum;
  logic [LEN:0] p_ext;

  // Add, then fold back into [0, p) with a single compare-and-subtract.
  // NOTE: every output of a combinational block is assigned on every path,
  // so no latch is inferred.
  always_comb begin
    p_ext = {1'b0, p};
    sum   = {1'b0, x} + {1'b0, y};
    s     = (sum >= p_ext) ? LEN'(sum - p_ext) : sum[LEN-1:0];
  end

endmodule

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: c = (a * b) mod p.
// The multiplier b is scanned MSB first, one bit per clock:
//   acc <- 2*acc mod p, then acc <- (acc + a) mod p when the current bit of b is 1.
// Each step keeps acc < p, so both modular adds need only one conditional subtract.
// Handshake: start is accepted when busy is low. done pulses once, LEN+1 clocks after
// the accepting edge. busy stays high through the done cycle. c holds the last result
// until the next operation reaches its done cycle.
module mod_mul_serial
  import ecc_pkg::*;
#(
  parameter int LEN = ECC_LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] p,
  output logic           busy,
  output logic           done,
  output logic [LEN-1:0] c
);

  // Counter selects the current multiplier bit, from LEN-1 down to 0.
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  mm_state_t      state;
  logic [LEN-1:0] a_reg;
  logic [LEN-1:0] b_reg;
  logic [LEN-1:0] p_reg;
  logic [LEN-1:0] acc;
  logic [CW-1:0]  cnt;

  // Step datapath: doubled accumulator, doubled-plus-a, and the selected next value.
  logic [LEN-1:0] acc_dbl;
  logic [LEN-1:0] acc_dbl_add;
  logic [LEN-1:0] acc_next;

  mod_add #(.LEN(LEN)) u_dbl (
    .x (acc),
    .y (acc),
    .p (p_reg),
    .s (acc_dbl)
  );

  mod_add #(.LEN(LEN)) u_acc (
    .x (acc_dbl),
    .y (a_reg),
    .p (p_reg),
    .s (acc_dbl_add)
  );

  // Pick the accumulate result only when the current multiplier bit is set.
  always_comb begin
    acc_next = b_reg[cnt] ? acc_dbl_add : acc_dbl;
  end

  // Sequencer: latch operands, run LEN steps, publish the result, then release busy.
  // NOTE: state is updated with non-blocking assignments, so every register samples
  // the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MM_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      c     <= '0;
      acc   <= '0;
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      p_reg <= '0;
    end else begin
      unique case (state)
        MM_IDLE: begin
          // The cycle after the done pulse is still busy; start is ignored there.
          done <= 1'b0;
          if (done) begin
            busy <= 1'b0;
          end else if (start && !busy) begin
            a_reg <= a;
            b_reg <= b;
            p_reg <= p;
            acc   <= '0;
            cnt   <= CNT_LAST;
            busy  <= 1'b1;
            state <= MM_RUN;
          end
        end

        MM_RUN: begin
          acc <= acc_next;
          if (cnt == '0) begin
            state <= MM_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        MM_DONE: begin
          c     <= acc;
          done  <= 1'b1;
          state <= MM_IDLE;
        end

        default: begin
          state <= MM_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_serial.sv
// Self-checking bench for mod_mul_serial at LEN=8: directed vector table,
// corner-case sequences (ignored start, mid-run reset) and random ops against (a*b)%p.
module tb_mod_mul_serial;

  localparam int LEN     = 8;
  localparam int LAT     = LEN + 2;  // negedges from driving start to seeing done
  localparam int TIMEOUT = 4 * LEN;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [LEN-1:0] a;
  logic [LEN-1:0] b;
  logic [LEN-1:0] p;
  logic           busy;
  logic           done;
  logic [LEN-1:0] c;

  int passed;
  int total;
  logic [LEN-1:0] prev_c;

  typedef struct {
    logic [LEN-1:0] a;
    logic [LEN-1:0] b;
    logic [LEN-1:0] p;
    logic [LEN-1:0] c;
  } vec_t;

  mod_mul_serial #(.LEN(LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Runs one operation starting at the next negedge. glitch_at > 0 pulses start with
  // different operands at that cycle; rst_at > 0 asserts reset at that cycle instead
  // of waiting for done.
  task automatic run_op(input string name, input logic [LEN-1:0] ta, input logic [LEN-1:0] tb_v,
                        input logic [LEN-1:0] tp, input logic [LEN-1:0] exp_c,
                        input int glitch_at, input int rst_at);
    int  lat;
    int  busy_cyc;
    int  dcount;
    bit  seen;
    bit  hold_ok;
    @(negedge clk);
    check({name, ":ready_busy"}, 32'(busy), 0);
    check({name, ":ready_done"}, 32'(done), 0);
    a = ta; b = tb_v; p = tp; start = 1'b1;
    lat = 0; busy_cyc = 0; seen = 1'b0; hold_ok = 1'b1;
    for (int k = 1; k <= TIMEOUT && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = LEN'($urandom); b = LEN'($urandom); p = LEN'($urandom);
      end
      if (k == glitch_at) begin
        start = 1'b1; a = 8'd5; b = 8'd5;
      end else if (glitch_at > 0 && k == glitch_at + 1) begin
        start = 1'b0;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check({name, ":rst_busy"}, 32'(busy), 0);
        check({name, ":rst_done"}, 32'(done), 0);
        check({name, ":rst_c"}, 32'(c), 0);
        dcount = 0;
        repeat (LEN + 3) begin
          @(negedge clk);
          if (done || busy) dcount++;
        end
        check({name, ":no_done_after_rst"}, 32'(dcount), 0);
        rst_n = 1'b1;
        prev_c = '0;
        return;
      end
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end else if (c !== prev_c) begin
        hold_ok = 1'b0;
      end
    end
    check({name, ":c"}, 32'(c), 32'(exp_c));
    check({name, ":latency"}, 32'(lat), LAT);
    check({name, ":busy_cycles"}, 32'(busy_cyc), LAT);
    check({name, ":c_held"}, 32'(hold_ok), 1);
    prev_c = exp_c;
  endtask

  initial begin
    vec_t vecs[10];
    logic [LEN-1:0] ra, rb, rp, rc;

    passed = 0; total = 0; prev_c = '0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; p = '0;

    vecs[0] = '{a: 8'd78,  b: 8'd31,  p: 8'd113, c: 8'd45};
    vecs[1] = '{a: 8'd28,  b: 8'd37,  p: 8'd47,  c: 8'd2};
    vecs[2] = '{a: 8'd250, b: 8'd250, p: 8'd251, c: 8'd1};
    vecs[3] = '{a: 8'd0,   b: 8'd200, p: 8'd251, c: 8'd0};
    vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 8'd2,   c: 8'd1};
    vecs[5] = '{a: 8'd112, b: 8'd112, p: 8'd113, c: 8'd1};
    vecs[6] = '{a: 8'd7,   b: 8'd9,   p: 8'd10,  c: 8'd3};
    vecs[7] = '{a: 8'd254, b: 8'd254, p: 8'd255, c: 8'd1};
    vecs[8] = '{a: 8'd200, b: 8'd3,   p: 8'd251, c: 8'd98};
    vecs[9] = '{a: 8'd17,  b: 8'd0,   p: 8'd19,  c: 8'd0};

    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_c", 32'(c), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, issued back to back (each start lands the cycle after done).
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].c, 0, 0);
    end

    // start pulsed mid-run with other operands is ignored.
    run_op("ignored_start", 8'd78, 8'd31, 8'd113, 8'd45, 3, 0);

    // Reset mid-run aborts without a done pulse; a fresh op then works.
    run_op("mid_reset", 8'd78, 8'd31, 8'd113, 8'd45, 0, 4);
    run_op("after_reset", 8'd28, 8'd37, 8'd47, 8'd2, 0, 0);

    // Random operands against the integer reference model.
    for (int i = 0; i < 1000; i++) begin
      rp = LEN'($urandom_range(255, 2));
      ra = LEN'($urandom_range(int'(rp) - 1, 0));
      rb = LEN'($urandom_range(int'(rp) - 1, 0));
      rc = LEN'((int'(ra) * int'(rb)) % int'(rp));
      run_op($sformatf("rand%0d", i), ra, rb, rp, rc, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
